// File: rtl/cycle_timer_pkg.sv
// Shared types and helpers for the cycle_timer block.
// Optional build macro handled by the top: CYCLE_TIMER_AUTORELOAD_EN.
package cycle_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    // Prescaler counter width; never narrower than one bit.
    function automatic int presc_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/cycle_timer_tick_prescaler.sv
// Free-running base-tick prescaler: counts 0..CLK_DIV-1 while enabled and
// strobes wrap on the edge where it rolls over.
module tick_prescaler
    import cycle_timer_pkg::*;
#(
    parameter int CLK_DIV = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sync_clr,
    output logic wrap
);

    localparam int PW = presc_width(CLK_DIV);
    localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] count;

    assign wrap = en && !sync_clr && (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (sync_clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + PW'(1);
        end
    end

endmodule

// File: rtl/cycle_timer.sv
// Up/down seconds-style timer with a programmable prescaler.
// Define CYCLE_TIMER_AUTORELOAD_EN to make down mode reload and repeat.
module cycle_timer
    import cycle_timer_pkg::*;
#(
    parameter int CLK_DIV = 1000000,
    parameter int CNT_W   = 7,
    parameter int MAX_CNT = 39
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             power,
    input  logic             start,
    input  logic             clear,
    input  logic             mode,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] ss,
    output logic             tick,
    output logic             done,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] ss_n;
    logic             tick_n, done_n;
    logic             mode_q, mode_n;
    logic             presc_clr, presc_en, wrap;
    logic [CNT_W-1:0] load_clamped;

`ifdef CYCLE_TIMER_AUTORELOAD_EN
    logic [CNT_W-1:0] reload_q, reload_n;
`endif

    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
    assign presc_en     = (state == RUN) && power;

    tick_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_presc (
        .clk      (clk),
        .reset    (reset),
        .en       (presc_en),
        .sync_clr (presc_clr),
        .wrap     (wrap)
    );

    // clear beats start, start beats a prescaler wrap
    always_comb begin
        state_n   = state;
        ss_n      = ss;
        tick_n    = 1'b0;
        done_n    = 1'b0;
        mode_n    = mode_q;
        presc_clr = 1'b0;
`ifdef CYCLE_TIMER_AUTORELOAD_EN
        reload_n  = reload_q;
`endif
        if (clear) begin
            state_n   = IDLE;
            ss_n      = '0;
            presc_clr = 1'b1;
        end else if (start) begin
            mode_n    = mode;
            presc_clr = 1'b1;
`ifdef CYCLE_TIMER_AUTORELOAD_EN
            reload_n  = load_clamped;
`endif
            if (mode == MODE_UP) begin
                ss_n    = '0;
                state_n = RUN;
            end else if (load_clamped != '0) begin
                ss_n    = load_clamped;
                state_n = RUN;
            end else begin
                ss_n    = '0;
                state_n = DONE;
                done_n  = 1'b1;
            end
        end else if (wrap) begin
            tick_n = 1'b1;
            if (mode_q == MODE_UP) begin
                if (ss == MAX_V) begin
                    ss_n   = '0;
                    done_n = 1'b1;
                end else begin
                    ss_n = ss + ONE;
                end
            end else if (ss > ONE) begin
                ss_n = ss - ONE;
            end else begin
                done_n = 1'b1;
`ifdef CYCLE_TIMER_AUTORELOAD_EN
                ss_n   = reload_q;
`else
                ss_n    = '0;
                state_n = DONE;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ss     <= '0;
            tick   <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
            mode_q <= MODE_UP;
        end else begin
            state  <= state_n;
            ss     <= ss_n;
            tick   <= tick_n;
            done   <= done_n;
            busy   <= (state_n == RUN);
            mode_q <= mode_n;
        end
    end

`ifdef CYCLE_TIMER_AUTORELOAD_EN
    // Reload value is only needed to restart a periodic down count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_n;
        end
    end
`endif

endmodule

// File: tb/tb_cycle_timer.sv
// Self-checking bench for cycle_timer with randomized stimulus and an
// arithmetic reference model (CLK_DIV=4, CNT_W=4, MAX_CNT=5).
module tb_cycle_timer;

    localparam int CLK_DIV = 4;
    localparam int CNT_W   = 4;
    localparam int MAX_CNT = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             power;
    logic             start;
    logic             clear;
    logic             mode;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] ss;
    logic             tick;
    logic             done;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    cycle_timer #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W),
        .MAX_CNT (MAX_CNT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .power    (power),
        .start    (start),
        .clear    (clear),
        .mode     (mode),
        .load_val (load_val),
        .ss       (ss),
        .tick     (tick),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Inputs other than start are scrambled afterwards to show they are sampled only on start.
    task automatic pulse_start(input logic m, input logic [CNT_W-1:0] lv);
        mode     = m;
        load_val = lv;
        start    = 1'b1;
        step();
        start    = 1'b0;
        mode     = 1'($urandom);
        load_val = CNT_W'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; power = 1'b0; start = 1'b0; clear = 1'b0;
        mode = 1'b0; load_val = '0;
        step(); step();
        checks++; if (ss !== 4'd0)   begin failures++; $display("[TB] FAIL rst_ss got=%0d want=0", ss); end
        checks++; if (tick !== 1'b0) begin failures++; $display("[TB] FAIL rst_tick got=%0b want=0", tick); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL rst_done got=%0b want=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy got=%0b want=0", busy); end
        reset = 1'b0; power = 1'b1;
        step();
        pulse_start(1'b0, CNT_W'($urandom));
        for (int k = 1; k <= 6; k++) step();
        checks++; if (ss !== 4'd1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL rst_prerun ss=%0d busy=%0b want ss=1 busy=1", ss, busy); end
        #3 reset = 1'b1;
        #1;
        checks++; if (ss !== 4'd0)   begin failures++; $display("[TB] FAIL rst_async_ss got=%0d want=0", ss); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_busy got=%0b want=0", busy); end
        checks++; if (tick !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_pulses tick=%0b done=%0b want 0 0", tick, done); end
        step();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (ss !== 4'd0 || busy !== 1'b0 || tick !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rst_idle k=%0d ss=%0d busy=%0b tick=%0b want 0 0 0", k, ss, busy, tick);
            end
        end
    endtask

    task automatic test_up(input int ncycles);
        logic [CNT_W-1:0] e_ss;
        logic             e_tick, e_done;
        power = 1'b1;
        pulse_start(1'b0, CNT_W'($urandom));
        for (int k = 0; k <= ncycles; k++) begin
            if (k > 0) step();
            e_ss   = CNT_W'((k / CLK_DIV) % (MAX_CNT + 1));
            e_tick = (k > 0) && (k % CLK_DIV == 0);
            e_done = e_tick && (e_ss == '0);
            checks++; if (ss !== e_ss)     begin failures++; $display("[TB] FAIL up_ss k=%0d got=%0d want=%0d", k, ss, e_ss); end
            checks++; if (tick !== e_tick) begin failures++; $display("[TB] FAIL up_tick k=%0d got=%0b want=%0b", k, tick, e_tick); end
            checks++; if (done !== e_done) begin failures++; $display("[TB] FAIL up_done k=%0d got=%0b want=%0b", k, done, e_done); end
            checks++; if (busy !== 1'b1)   begin failures++; $display("[TB] FAIL up_busy k=%0d got=%0b want=1", k, busy); end
        end
    endtask

    task automatic test_down(input int load);
        int r, n, limit;
        logic             ktick;
        logic [CNT_W-1:0] e_ss;
        logic             e_tick, e_done, e_busy;
        r = (load > MAX_CNT) ? MAX_CNT : load;
`ifdef CYCLE_TIMER_AUTORELOAD_EN
        limit = CLK_DIV * r * 3 + 2;
`else
        limit = CLK_DIV * r + 20;
`endif
        power = 1'b1;
        pulse_start(1'b1, CNT_W'(load));
        for (int k = 0; k <= limit; k++) begin
            if (k > 0) step();
            n     = k / CLK_DIV;
            ktick = (k > 0) && (k % CLK_DIV == 0);
`ifdef CYCLE_TIMER_AUTORELOAD_EN
            e_ss   = CNT_W'(r - (n % r));
            e_tick = ktick;
            e_done = ktick && (n % r == 0);
            e_busy = 1'b1;
`else
            e_ss   = (n < r) ? CNT_W'(r - n) : '0;
            e_busy = (n < r);
            e_tick = ktick && (n <= r);
            e_done = ktick && (n == r);
`endif
            checks++; if (ss !== e_ss)     begin failures++; $display("[TB] FAIL dn_ss load=%0d k=%0d got=%0d want=%0d", load, k, ss, e_ss); end
            checks++; if (tick !== e_tick) begin failures++; $display("[TB] FAIL dn_tick load=%0d k=%0d got=%0b want=%0b", load, k, tick, e_tick); end
            checks++; if (done !== e_done) begin failures++; $display("[TB] FAIL dn_done load=%0d k=%0d got=%0b want=%0b", load, k, done, e_done); end
            checks++; if (busy !== e_busy) begin failures++; $display("[TB] FAIL dn_busy load=%0d k=%0d got=%0b want=%0b", load, k, busy, e_busy); end
        end
    endtask

    task automatic test_load_zero();
        int ticks_seen, dones_seen;
        power = 1'b1;
        pulse_start(1'b0, '0);
        for (int k = 0; k < 5; k++) step();
        pulse_start(1'b1, '0);
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL zero_done got=%0b want=1", done); end
        checks++; if (ss !== 4'd0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL zero_state ss=%0d busy=%0b want 0 0", ss, busy); end
        ticks_seen = 0;
        dones_seen = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (tick) ticks_seen++;
            if (done) dones_seen++;
        end
        checks++; if (ticks_seen != 0) begin failures++; $display("[TB] FAIL zero_ticks got=%0d want=0", ticks_seen); end
        checks++; if (dones_seen != 0) begin failures++; $display("[TB] FAIL zero_extra_done got=%0d want=0", dones_seen); end
        checks++; if (ss !== 4'd0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL zero_hold ss=%0d busy=%0b want 0 0", ss, busy); end
    endtask

    // Model counts powered edges since start; count and ticks follow from that alone.
    task automatic test_power();
        int p;
        logic pw;
        logic [CNT_W-1:0] e_ss;
        logic             e_tick, e_done;
        power = 1'b1;
        pulse_start(1'b0, CNT_W'($urandom));
        p = 0;
        for (int k = 0; k < 60; k++) begin
            if (k < 6)       pw = 1'b1;
            else if (k < 16) pw = 1'b0;
            else if (k < 18) pw = 1'b1;
            else             pw = 1'($urandom);
            power = pw;
            step();
            if (pw) p++;
            e_ss   = CNT_W'((p / CLK_DIV) % (MAX_CNT + 1));
            e_tick = pw && (p % CLK_DIV == 0);
            e_done = e_tick && (e_ss == '0);
            checks++; if (ss !== e_ss)     begin failures++; $display("[TB] FAIL pwr_ss k=%0d got=%0d want=%0d", k, ss, e_ss); end
            checks++; if (tick !== e_tick) begin failures++; $display("[TB] FAIL pwr_tick k=%0d got=%0b want=%0b", k, tick, e_tick); end
            checks++; if (done !== e_done) begin failures++; $display("[TB] FAIL pwr_done k=%0d got=%0b want=%0b", k, done, e_done); end
            checks++; if (busy !== 1'b1)   begin failures++; $display("[TB] FAIL pwr_busy k=%0d got=%0b want=1", k, busy); end
        end
        power = 1'b1;
    endtask

    task automatic test_back_to_back();
        test_up(6);
        test_up(10);
        test_down(2 + int'($urandom_range(0, 3)));
        test_up(9);
    endtask

    task automatic test_clear();
        power = 1'b1;
        pulse_start(1'b0, '0);
        for (int k = 0; k < 9; k++) step();
        power    = 1'b0;
        clear    = 1'b1;
        start    = 1'b1;
        mode     = 1'b1;
        load_val = 4'd3;
        step();
        clear = 1'b0;
        start = 1'b0;
        checks++; if (ss !== 4'd0)   begin failures++; $display("[TB] FAIL clr_ss got=%0d want=0", ss); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL clr_busy got=%0b want=0", busy); end
        checks++; if (tick !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL clr_pulses tick=%0b done=%0b want 0 0", tick, done); end
        power = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (ss !== 4'd0 || busy !== 1'b0 || tick !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL clr_idle k=%0d ss=%0d busy=%0b tick=%0b done=%0b want all 0", k, ss, busy, tick, done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up(50);
        test_down(3);
        test_down(9);
        test_down(int'($urandom_range(1, 15)));
        test_load_zero();
        test_power();
        test_back_to_back();
        test_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cycle_timer.md
Name: cycle_timer

Overview:
- Parametrised seconds-style timer for appliance control panels. A programmable prescaler divides clk into base ticks, and a CNT_W-bit counter runs up (wrapping at MAX_CNT) or down (from a loaded value to 0).
- Gated by `power`, controlled by `start`/`clear`. Reports `tick`, `done` and `busy` to the control FSM and display logic.

Parameters:
- CLK_DIV, 1000000: clk cycles per tick; must be >= 2.
- CNT_W, 7: width of the count output.
- MAX_CNT, 39: highest count value; must be < 2**CNT_W.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- power  in  1  count enable; low freezes prescaler and count.
- start  in  1  one-cycle pulse; (re)starts the timer.
- clear  in  1  one-cycle pulse; synchronous return to idle.
- mode  in  1  0 = up, 1 = down; sampled on start only.
- load_val  in  CNT_W  down-mode start value; sampled on start.
- ss  out  CNT_W  current count.
- tick  out  1  one-cycle pulse, coincident with each ss update.
- done  out  1  one-cycle pulse on terminal event.
- busy  out  1  high while in RUN.

Behaviour:
- Reset:
  - State IDLE; ss, prescaler, tick, done, busy all 0.
  - Stored mode and reload value 0.
  - Takes effect mid-operation immediately.
- States IDLE, RUN, DONE. busy = (state == RUN), registered.
- Priority per edge: clear > start > counting.
- clear:
  - State IDLE; ss = 0; prescaler = 0; tick/done = 0.
  - Honoured regardless of power.
- start, in any state and regardless of power:
  - Latch mode.
  - Latch reload value = min(load_val, MAX_CNT).
  - Prescaler = 0.
  - Up mode: ss = 0, state RUN.
  - Down mode, reload > 0: ss = reload, state RUN.
  - Down mode, reload == 0: ss = 0, state DONE, done high in the next cycle.
- Prescaler:
  - Width $clog2(CLK_DIV). Advances only when RUN and power = 1.
  - Counts 0..CLK_DIV-1.
  - On the edge where it equals CLK_DIV-1: wraps to 0, ss updates, and tick is high for the following cycle.
  - First tick is CLK_DIV powered cycles after start.
- Up mode, per tick:
  - ss < MAX_CNT: ss + 1.
  - ss == MAX_CNT: ss = 0, done pulses with tick.
  - Stays in RUN until clear or start.
- Down mode, per tick:
  - ss > 1: ss - 1.
  - ss == 1: ss = 0, done pulses with tick, state DONE.
- DONE: ss holds, no ticks, waits for start or clear.
- power = 0 in RUN:
  - Prescaler and ss hold; tick = 0.
  - Resumes with the remaining prescaler count when power returns.
- tick and done never exceed one cycle.
- start while RUN discards the partial prescaler count.

Optional Feature:
- Macro: CYCLE_TIMER_AUTORELOAD_EN.
- Defined, down mode, tick with ss == 1:
  - ss = stored reload value, done pulses, state stays RUN.
  - Periodic timer with period = reload ticks.
  - Reload 0 still goes to DONE as in the base behaviour.
- Undefined: base behaviour only, and no extra logic.
- Up mode is identical in both builds.

Decomposition:
- Package cycle_timer_pkg:
  - State enum (IDLE, RUN, DONE).
  - Mode constants MODE_UP = 0, MODE_DOWN = 1.
  - Helper function for the prescaler width.
- One natural sub-module, tick_prescaler:
  - Parameter CLK_DIV; inputs clk, reset, en, sync_clr; output wrap strobe.
  - Holds the counter only.
- Count/FSM logic stays in cycle_timer.

Test Plan (CLK_DIV = 4, CNT_W = 4, MAX_CNT = 5):
- Reset asserted mid-RUN -> ss, tick, done, busy all 0 immediately; IDLE after release.
- start, mode 0, power 1:
  - ss steps 0,1,2,3,4,5,0 every 4 cycles, with tick each step.
  - done only on the 5->0 step; busy stays 1.
- start, mode 1, load_val 3:
  - ss 3,2,1,0, done with the final tick; busy falls.
  - ss holds 0 for 20 more cycles with no tick.
- Mid-RUN, power low 10 cycles after 2 prescaler counts -> ss frozen, no tick; next tick exactly 2 powered cycles after power returns.
- Load clamping:
  - load_val 9, down -> ss = 5.
  - load_val 0, down -> DONE, single done pulse, zero ticks.
- clear and start same cycle -> IDLE, ss 0, busy 0.
- With CYCLE_TIMER_AUTORELOAD_EN, down, load 2 -> ss 2,1,2,1,... with done on each 1->reload step; busy stays 1.
